address_generation_top: RTL

//  Pipeline stage directly upstream of memory_read_top. Accepts register-read operands from decode,

---
 rtl/address_generation_top.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/address_generation_top.sv
// Address generation stage: EA = base + index<<scale + disp, or push/pop stack address; feeds memory read.
// Latency: 1 cycle from d accept to a_valid. Optional feature macro: AGEN_SKID_EN (2-entry skid buffer).
// Backpressure: AGEN_SKID_EN -> registered d_ready = !entry1_valid; otherwise d_ready = !a_valid || a_ready.
module address_generation_top #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_base,
    input  logic [ADDR_W-1:0] d_index,
    input  logic [1:0]        d_scale,
    input  logic [ADDR_W-1:0] d_disp,
    input  logic              d_use_base,
    input  logic              d_use_index,
    input  logic [ADDR_W-1:0] d_esp,
    input  logic [1:0]        d_stack_op,
    input  logic [63:0]       d_op0,
    input  logic [63:0]       d_op1,
    input  logic [2:0]        d_op0_reg,
    input  logic [2:0]        d_op1_reg,
    input  logic              d_op0_is_address,
    input  logic              d_op1_is_address,
    input  logic [47:0]       d_imm,
    input  logic [31:0]       d_pc,
    input  logic [13:0]       d_ctrl,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [2:0]        a_size,
    output logic [63:0]       a_op0,
    output logic [63:0]       a_op1,
    output logic [2:0]        a_op0_reg,
    output logic [2:0]        a_op1_reg,
    output logic              a_op0_is_address,
    output logic              a_op1_is_address,
    output logic [47:0]       a_imm,
    output logic [1:0]        a_stack_op,
    output logic [31:0]       a_pc,
    output logic [13:0]       a_ctrl
);

    typedef struct packed {
        logic [2:0]  size;
        logic [63:0] op0;
        logic [63:0] op1;
        logic [2:0]  op0_reg;
        logic [2:0]  op1_reg;
        logic        op0_is_address;
        logic        op1_is_address;
        logic [47:0] imm;
        logic [1:0]  stack_op;
        logic [31:0] pc;
        logic [13:0] ctrl;
    } agen_pay_t;

    logic [ADDR_W-1:0] nbytes;
    logic [ADDR_W-1:0] scaled_index;
    logic [ADDR_W-1:0] ea_sum;
    logic [ADDR_W-1:0] ea;
    logic [63:0]       ea_ext;
    agen_pay_t         pay_in;

    always_comb begin
        case (d_size)
            3'd0:    nbytes = ADDR_W'(1);
            3'd1:    nbytes = ADDR_W'(2);
            3'd2:    nbytes = ADDR_W'(4);
            default: nbytes = ADDR_W'(8);
        endcase
    end

    assign scaled_index = d_index << d_scale;
    assign ea_sum = (d_use_base ? d_base : '0)
                  + (d_use_index ? scaled_index : '0)
                  + d_disp;

    // Stack ops ignore base/index/disp entirely; reserved encoding behaves as no stack op.
    always_comb begin
        case (d_stack_op)
            2'd1:    ea = d_esp - nbytes;
            2'd2:    ea = d_esp;
            default: ea = ea_sum;
        endcase
    end

    assign ea_ext = 64'(ea);

    always_comb begin
        pay_in                = '0;
        pay_in.size           = d_size;
        pay_in.op0            = d_op0_is_address ? ea_ext : d_op0;
        // Only one operand can carry the EA; op0 wins when both are flagged.
        pay_in.op1            = (d_op1_is_address && !d_op0_is_address) ? ea_ext : d_op1;
        pay_in.op0_reg        = d_op0_reg;
        pay_in.op1_reg        = d_op1_reg;
        pay_in.op0_is_address = d_op0_is_address;
        pay_in.op1_is_address = d_op1_is_address;
        pay_in.imm            = d_imm;
        pay_in.stack_op       = d_stack_op;
        pay_in.pc             = d_pc;
        pay_in.ctrl           = d_ctrl;
    end

    logic      e0_vld;
    agen_pay_t e0_dat;

`ifdef AGEN_SKID_EN
    logic      e1_vld;
    agen_pay_t e1_dat;

    assign d_ready = !e1_vld;

    // entry1 only fills when entry0 is stalled; it is promoted on the next drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_vld <= 1'b0;
            e1_vld <= 1'b0;
            e0_dat <= '0;
            e1_dat <= '0;
        end else if (flush) begin
            e0_vld <= 1'b0;
            e1_vld <= 1'b0;
        end else if (!e0_vld || a_ready) begin
            if (e1_vld) begin
                e0_vld <= 1'b1;
                e0_dat <= e1_dat;
                e1_vld <= 1'b0;
            end else begin
                e0_vld <= d_valid;
                if (d_valid) e0_dat <= pay_in;
            end
        end else if (d_valid && !e1_vld) begin
            e1_vld <= 1'b1;
            e1_dat <= pay_in;
        end
    end
`else
    assign d_ready = !e0_vld || a_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_vld <= 1'b0;
            e0_dat <= '0;
        end else if (flush) begin
            e0_vld <= 1'b0;
        end else if (d_ready) begin
            e0_vld <= d_valid;
            if (d_valid) e0_dat <= pay_in;
        end
    end
`endif

    assign a_valid          = e0_vld;
    assign a_size           = e0_dat.size;
    assign a_op0            = e0_dat.op0;
    assign a_op1            = e0_dat.op1;
    assign a_op0_reg        = e0_dat.op0_reg;
    assign a_op1_reg        = e0_dat.op1_reg;
    assign a_op0_is_address = e0_dat.op0_is_address;
    assign a_op1_is_address = e0_dat.op1_is_address;
    assign a_imm            = e0_dat.imm;
    assign a_stack_op       = e0_dat.stack_op;
    assign a_pc             = e0_dat.pc;
    assign a_ctrl           = e0_dat.ctrl;

endmodule
